// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ packet sources.
// A grant is held for a whole packet, honouring f_full per beat and a MAX_BURST limit.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                          w_clk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          f_full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          busy,
    output logic                          burst_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] LAST_CNT = BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] TOP_ID   = IDW'(NUM_REQ - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                  state;
    logic [IDW-1:0]          rr_ptr;
    logic [BCW-1:0]          beat_cnt;

    logic [IDW-1:0]          winner;
    logic [IDW-1:0]          cand;
    logic                    found;
    int                      idx;

    logic                    gnt_req;
    logic                    gnt_last;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic                    beat;

    // Search upward from rr_ptr, wrapping modulo NUM_REQ; first requester found wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        gnt_req  = 1'b0;
        gnt_last = 1'b0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                gnt_req  = req[i];
                gnt_last = req_last[i];
                gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign beat = (state == LOCK) && gnt_req && !f_full;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == LOCK) && (gnt_id == IDW'(i)) && !f_full;
        end
    end

    assign w_en    = beat;
    assign data_in = beat ? gnt_data : '0;

    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            state     <= IDLE;
            gnt_id    <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            busy      <= 1'b0;
            burst_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_id   <= winner;
                        beat_cnt <= '0;
                        state    <= LOCK;
                        busy     <= 1'b1;
                    end
                end
                LOCK: begin
                    if (beat) begin
                        // Release on the packet's last beat, or forcibly once MAX_BURST beats went out.
                        if (gnt_last || (beat_cnt == LAST_CNT)) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            beat_cnt <= '0;
                            rr_ptr   <= (gnt_id == TOP_ID) ? '0 : gnt_id + 1'b1;
                            if (!gnt_last) begin
                                burst_err <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
